// File: rtl/apx_fmul_arbiter.sv
// Round-robin arbiter sharing one apx_float_multiplier among N_REQ requesters.
// Sequences the multiplier's a/b/z stb-ack handshakes, one operation in flight.
module apx_fmul_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [32*N_REQ-1:0]   req_a,
  input  logic [32*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]      req_ack,
  output logic [31:0]           res_z,
  output logic [N_REQ-1:0]      res_stb,
  input  logic [N_REQ-1:0]      res_ack,
  output logic [31:0]           mul_a,
  output logic                  mul_a_stb,
  input  logic                  mul_a_ack,
  output logic [31:0]           mul_b,
  output logic                  mul_b_stb,
  input  logic                  mul_b_ack,
  input  logic [31:0]           mul_z,
  input  logic                  mul_z_stb,
  output logic                  mul_z_ack,
  output logic                  busy,
  output logic [IDX_W-1:0]      grant_idx,
  output logic [CNT_W-1:0]      ops_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SEND_A = 3'd1;
  localparam logic [2:0] S_SEND_B = 3'd2;
  localparam logic [2:0] S_WAIT_Z = 3'd3;
  localparam logic [2:0] S_RETURN = 3'd4;

  logic [2:0]       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] next_ptr;
  logic             found;
  logic [N_REQ-1:0] pick_oh;
  logic [N_REQ-1:0] grant_oh;

  // Scan from rr_ptr upward with wrap; the first pending requester wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = IDX_W'((int'(rr_ptr) + i) % N_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign pick_oh  = N_REQ'(1) << pick;
  assign grant_oh = N_REQ'(1) << grant_idx;
  assign next_ptr = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      req_ack   <= '0;
      res_stb   <= '0;
      res_z     <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_a_stb <= 1'b0;
      mul_b_stb <= 1'b0;
      mul_z_ack <= 1'b0;
      grant_idx <= '0;
      ops_done  <= '0;
    end else begin
      req_ack <= '0;
      case (state)
        S_IDLE: begin
          if (found) begin
            mul_a     <= req_a[32*pick +: 32];
            mul_b     <= req_b[32*pick +: 32];
            grant_idx <= pick;
            req_ack   <= pick_oh;
            mul_a_stb <= 1'b1;
            state     <= S_SEND_A;
          end
        end
        S_SEND_A: begin
          if (mul_a_stb && mul_a_ack) begin
            mul_a_stb <= 1'b0;
            mul_b_stb <= 1'b1;
            state     <= S_SEND_B;
          end
        end
        S_SEND_B: begin
          if (mul_b_stb && mul_b_ack) begin
            mul_b_stb <= 1'b0;
            mul_z_ack <= 1'b1;
            state     <= S_WAIT_Z;
          end
        end
        S_WAIT_Z: begin
          if (mul_z_stb && mul_z_ack) begin
            res_z     <= mul_z;
            mul_z_ack <= 1'b0;
            res_stb   <= grant_oh;
            state     <= S_RETURN;
          end
        end
        S_RETURN: begin
          // Only the grantee's res_ack completes delivery.
          if ((res_stb & res_ack & grant_oh) != '0) begin
            res_stb  <= '0;
            ops_done <= ops_done + 1'b1;
            rr_ptr   <= next_ptr;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apx_fmul_arbiter.sv
// Bench for apx_fmul_arbiter: behavioural multiplier responder plus a
// round-robin reference model driven by directed and random operations.
module tb_apx_fmul_arbiter;

  localparam int N     = 4;
  localparam int IDX_W = 2;
  localparam int CNT_W = 4;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [32*N-1:0]   req_a;
  logic [32*N-1:0]   req_b;
  logic [N-1:0]      req_ack;
  logic [31:0]       res_z;
  logic [N-1:0]      res_stb;
  logic [N-1:0]      res_ack;
  logic [31:0]       mul_a;
  logic              mul_a_stb;
  logic              mul_a_ack;
  logic [31:0]       mul_b;
  logic              mul_b_stb;
  logic              mul_b_ack;
  logic [31:0]       mul_z;
  logic              mul_z_stb;
  logic              mul_z_ack;
  logic              busy;
  logic [IDX_W-1:0]  grant_idx;
  logic [CNT_W-1:0]  ops_done;

  int checks = 0;
  int errors = 0;

  int          ptr_m;
  int          ops_m;
  logic [31:0] op_a [N];
  logic [31:0] op_b [N];
  int          g_got;
  logic [31:0] z_got;
  bit          z_hold;

  apx_fmul_arbiter #(.N_REQ(N), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ack(req_ack),
    .res_z(res_z), .res_stb(res_stb), .res_ack(res_ack),
    .mul_a(mul_a), .mul_a_stb(mul_a_stb), .mul_a_ack(mul_a_ack),
    .mul_b(mul_b), .mul_b_stb(mul_b_stb), .mul_b_ack(mul_b_ack),
    .mul_z(mul_z), .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack),
    .busy(busy), .grant_idx(grant_idx), .ops_done(ops_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic real s2r(input logic [31:0] s);
    logic [63:0] d;
    if (s[30:0] == 31'd0) return 0.0;
    d = {s[31], 11'(int'(s[30:23]) - 127 + 1023), s[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  // Small exact values so every product is representable without rounding.
  function automatic logic [31:0] rnd_op();
    int  k, e;
    real r;
    k = int'($urandom_range(15, 1));
    e = int'($urandom_range(8, 0)) - 4;
    r = k * (2.0 ** e);
    if ($urandom_range(1, 0) == 1) r = -r;
    return r2s(r);
  endfunction

  // Multiplier responder: random ack delays, stray acks, random z latency.
  initial begin : mult_stub
    logic [31:0] sa, zv;
    bit zr, zf;
    int zd;
    mul_a_ack = 0; mul_b_ack = 0; mul_z_stb = 0; mul_z = 0;
    sa = 0; zv = 0; zr = 0; zf = 0; zd = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mul_a_ack = 0; mul_b_ack = 0; mul_z_stb = 0; mul_z = 0;
        zr = 0; zf = 0; zd = 0;
      end else begin
        if (zf) begin
          mul_z_stb = 0; zf = 0; zr = 0; mul_z = $urandom;
        end
        mul_a_ack = mul_a_stb ? ($urandom_range(1, 0) == 1) : ($urandom_range(5, 0) == 0);
        if (mul_a_stb && mul_a_ack) sa = mul_a;
        mul_b_ack = mul_b_stb ? ($urandom_range(1, 0) == 1) : ($urandom_range(5, 0) == 0);
        if (mul_b_stb && mul_b_ack) begin
          zv = r2s(s2r(sa) * s2r(mul_b));
          zr = 1; zd = int'($urandom_range(3, 0));
        end
        if (zr && !zf && !z_hold) begin
          if (zd > 0) zd--;
          else begin mul_z_stb = 1; mul_z = zv; end
        end
        if (mul_z_stb && mul_z_ack) zf = 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ctl"}, {req_ack, res_stb, mul_a_stb, mul_b_stb, mul_z_ack, busy, grant_idx, ops_done}, 64'd0);
    chk({tag, "_data"}, {res_z, mul_a}, 64'd0);
    chk({tag, "_mulb"}, mul_b, 64'd0);
  endtask

  task automatic apply_reset();
    rst = 0; req_valid = '0; res_ack = '0;
    repeat (2) @(negedge clk);
    rst = 1; ptr_m = 0; ops_m = 0;
    @(negedge clk);
  endtask

  // One full operation: grant, operand capture, multiply, delivery with bp cycles of back-pressure.
  task automatic do_op(input logic [N-1:0] vmask, input int bp);
    int          eg, bd;
    logic [31:0] ez, hz;
    logic [N-1:0] eoh, hstb;
    bit          seen;
    eg = 0; bd = N;
    for (int i = 0; i < N; i++)
      if (vmask[i] && ((i - ptr_m + N) % N) < bd) begin
        bd = (i - ptr_m + N) % N; eg = i;
      end
    eoh = N'(1) << eg;
    ez  = r2s(s2r(op_a[eg]) * s2r(op_b[eg]));
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = op_a[i];
      req_b[32*i +: 32] = op_b[i];
    end
    req_valid = vmask;
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = (req_ack != '0);
    end
    chk("req_ack_seen", 64'(seen), 64'd1);
    if (!seen) return;
    chk("req_ack_onehot", 64'(req_ack), 64'(eoh));
    chk("grant_idx", 64'(grant_idx), 64'(eg));
    chk("busy_granted", 64'(busy), 64'd1);
    req_a = {$urandom, $urandom, $urandom, $urandom};
    req_b = {$urandom, $urandom, $urandom, $urandom};
    req_valid = N'($urandom);
    @(negedge clk);
    chk("req_ack_pulse", 64'(req_ack), 64'd0);
    seen = (res_stb != '0);
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      seen = (res_stb != '0);
    end
    chk("res_stb_seen", 64'(seen), 64'd1);
    if (!seen) return;
    chk("res_stb_onehot", 64'(res_stb), 64'(eoh));
    chk("res_z", 64'(res_z), 64'(ez));
    hz = res_z; hstb = res_stb;
    for (int c = 0; c < bp; c++) begin
      res_ack = N'($urandom) & ~eoh;
      req_valid = N'($urandom);
      @(negedge clk);
      chk("hold", {res_z, 4'(res_stb), 4'(req_ack), 3'd0, busy}, {hz, 4'(hstb), 4'd0, 3'd0, 1'b1});
    end
    res_ack = eoh | (N'($urandom) & ~eoh);
    req_valid = '0;
    @(negedge clk);
    res_ack = '0;
    ptr_m = (eg + 1) % N;
    ops_m = (ops_m + 1) % (1 << CNT_W);
    chk("released", {4'(res_stb), 3'd0, busy}, 8'd0);
    chk("ops_done", 64'(ops_done), 64'(ops_m));
    g_got = eg;
    z_got = hz;
  endtask

  initial begin : main
    bit seen;
    z_hold = 0; rst = 0; req_valid = '0; res_ack = '0; req_a = '0; req_b = '0;
    ptr_m = 0; ops_m = 0;
    for (int i = 0; i < N; i++) begin op_a[i] = rnd_op(); op_b[i] = rnd_op(); end
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1;
    @(negedge clk);

    // Single op: 2.0 * 3.0
    op_a[0] = 32'h4000_0000; op_b[0] = 32'h4040_0000;
    do_op(4'b0001, 0);
    chk("t1_z", 64'(z_got), 64'h40C0_0000);
    chk("t1_ops", 64'(ops_done), 64'd1);

    // All four pending from reset, 1.5 * 1.5
    apply_reset();
    for (int i = 0; i < N; i++) begin op_a[i] = 32'h3FC0_0000; op_b[i] = 32'h3FC0_0000; end
    for (int k = 0; k < 4; k++) begin
      do_op(4'b1111, 0);
      chk("t2_grant", 64'(g_got), 64'(k));
      chk("t2_z", 64'(z_got), 64'h4010_0000);
    end
    chk("t2_ops", 64'(ops_done), 64'd4);

    // Fairness between requesters 0 and 2
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) begin op_a[i] = rnd_op(); op_b[i] = rnd_op(); end
      do_op(4'b0101, 0);
      chk("t3_grant", 64'(g_got), (k % 2 == 0) ? 64'd0 : 64'd2);
    end

    // Back-pressure on requester 1
    op_a[1] = rnd_op(); op_b[1] = rnd_op();
    do_op(4'b0010, 20);
    chk("t4_grant", 64'(g_got), 64'd1);

    // Random traffic
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < N; i++) begin op_a[i] = rnd_op(); op_b[i] = rnd_op(); end
      do_op(N'($urandom_range(15, 1)), int'($urandom_range(3, 0)));
    end

    // Async reset while waiting for the product
    z_hold = 1;
    op_a[2] = rnd_op(); op_b[2] = rnd_op();
    req_a[64 +: 32] = op_a[2]; req_b[64 +: 32] = op_b[2];
    req_valid = 4'b0100;
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      seen = mul_z_ack;
    end
    chk("t5_wait_z_seen", 64'(seen), 64'd1);
    req_valid = '0;
    #2 rst = 0;
    #1 chk_zero_outputs("t5_async");
    @(negedge clk);
    chk_zero_outputs("t5_held");
    @(negedge clk);
    rst = 1; z_hold = 0; ptr_m = 0; ops_m = 0;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin op_a[i] = rnd_op(); op_b[i] = rnd_op(); end
    do_op(4'b1111, 0);
    chk("t5_grant", 64'(g_got), 64'd0);

    // Counter wrap at CNT_W=4
    apply_reset();
    for (int k = 0; k < 17; k++) begin
      for (int i = 0; i < N; i++) begin op_a[i] = rnd_op(); op_b[i] = rnd_op(); end
      do_op(N'($urandom_range(15, 1)), 0);
    end
    chk("t6_wrap", 64'(ops_done), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
